// File: rtl/seq_shift_register_pkg.sv
// Shared types for the sequenced shift register: shift modes, FSM states
// and the reserved-mode decoder.
package seq_shift_pkg;

    typedef enum logic [2:0] {
        MODE_ROR = 3'd0,
        MODE_ROL = 3'd1,
        MODE_LSR = 3'd2,
        MODE_LSL = 3'd3,
        MODE_ASR = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Codes 5..7 have no shift behaviour; a start with one of them completes at once.
    function automatic logic is_reserved(input logic [2:0] mode);
        return (mode > 3'd4);
    endfunction

endpackage

// File: rtl/seq_shift_register_if.sv
// Request/status bundle between a controller (master) and the shift register (slave).
interface seq_shift_register_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] q;
    logic             shift_out;
    logic             busy;
    logic             done;

    modport master (
        output load, data_in, start, mode, amount,
        input  q, shift_out, busy, done
    );

    modport slave (
        input  load, data_in, start, mode, amount,
        output q, shift_out, busy, done
    );
endinterface

// File: rtl/seq_shift_register_step.sv
// Combinational single-position step: given the current word and mode,
// produces the word after one shift/rotate and the bit pushed out.
module shift_step_unit
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  mode_t            mode_r_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             out_o
);

    always_comb begin
        q_next_o = q_i;
        out_o    = 1'b0;
        case (mode_r_i)
            MODE_ROR: begin
                q_next_o = {q_i[0], q_i[WIDTH-1:1]};
                out_o    = q_i[0];
            end
            MODE_ROL: begin
                q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                out_o    = q_i[WIDTH-1];
            end
            MODE_LSR: begin
                q_next_o = {1'b0, q_i[WIDTH-1:1]};
                out_o    = q_i[0];
            end
            MODE_LSL: begin
                q_next_o = {q_i[WIDTH-2:0], 1'b0};
                out_o    = q_i[WIDTH-1];
            end
            MODE_ASR: begin
                q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
                out_o    = q_i[0];
            end
            default: begin
                q_next_o = q_i;
                out_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_register.sv
// Multi-mode shift/rotate register that walks a requested distance one bit
// per clock, with parallel load/abort and a busy/done handshake.
module seq_shift_register
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    seq_shift_register_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             shiftOut_q, shiftOut_d;
    logic [AMT_W-1:0] count_q, count_d;
    mode_t            modeR_q, modeR_d;
    logic [WIDTH-1:0] stepWord;
    logic             stepOut;
    logic             busy;
    logic             done;

    shift_step_unit #(
        .WIDTH(WIDTH)
    ) stepUnit (
        .q_i      (word_q),
        .mode_r_i (modeR_q),
        .q_next_o (stepWord),
        .out_o    (stepOut)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            shiftOut_q <= 1'b0;
            count_q    <= '0;
            modeR_q    <= MODE_ROR;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            shiftOut_q <= shiftOut_d;
            count_q    <= count_d;
            modeR_q    <= modeR_d;
        end
    end

    // Load wins over start in IDLE and aborts a shift in progress; DONE ignores both.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        shiftOut_d = shiftOut_q;
        count_d    = count_q;
        modeR_d    = modeR_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    word_d     = bus.data_in;
                    shiftOut_d = 1'b0;
                end else if (bus.start) begin
                    if ((bus.amount == '0) || is_reserved(bus.mode)) begin
                        state_d = DONE;
                    end else begin
                        modeR_d = mode_t'(bus.mode);
                        count_d = bus.amount;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (bus.load) begin
                    word_d     = bus.data_in;
                    shiftOut_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    word_d     = stepWord;
                    shiftOut_d = stepOut;
                    count_d    = count_q - AMT_W'(1);
                    if (count_q == AMT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    assign bus.q         = word_q;
    assign bus.shift_out = shiftOut_q;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_seq_shift_register.sv
// Directed bench for seq_shift_register (WIDTH=8): expected per-cycle outputs
// are queued as each step is driven and checked one time unit after the edge.
module tb_seq_shift_register;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       so;
        logic       busy;
        logic       done;
    } exp_t;

    logic clock;
    logic reset;
    exp_t sbQ[$];
    int   compared;
    int   mismatched;

    seq_shift_register_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    seq_shift_register #(
        .WIDTH(WIDTH),
        .AMT_W(AMT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic rst, input logic ld, input logic [7:0] din,
                                 input logic st, input logic [2:0] md, input logic [3:0] amt);
        reset       = rst;
        bus.load    = ld;
        bus.data_in = din;
        bus.start   = st;
        bus.mode    = md;
        bus.amount  = amt;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
            return;
        end
        e = sbQ.pop_front();
        compared++;
        assert (bus.q === e.q) else begin
            mismatched++;
            $error("FAIL %s.q: observed %h expected %h", e.tag, bus.q, e.q);
        end
        compared++;
        assert (bus.shift_out === e.so) else begin
            mismatched++;
            $error("FAIL %s.shift_out: observed %b expected %b", e.tag, bus.shift_out, e.so);
        end
        compared++;
        assert (bus.busy === e.busy) else begin
            mismatched++;
            $error("FAIL %s.busy: observed %b expected %b", e.tag, bus.busy, e.busy);
        end
        compared++;
        assert (bus.done === e.done) else begin
            mismatched++;
            $error("FAIL %s.done: observed %b expected %b", e.tag, bus.done, e.done);
        end
    endtask

    // Queue the expected post-edge outputs, clock once, then compare.
    task automatic stepCycle(input string tag, input logic [7:0] q, input logic so,
                             input logic busy, input logic done);
        exp_t e;
        e.tag  = tag;
        e.q    = q;
        e.so   = so;
        e.busy = busy;
        e.done = done;
        sbQ.push_back(e);
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [7:0] lslExp;
        compared   = 0;
        mismatched = 0;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 4'd0);
        @(negedge clock);

        stepCycle("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 8'hB4, 1'b0, 3'd0, 4'd0);
        stepCycle("load_b4", 8'hB4, 1'b0, 1'b0, 1'b0);

        // ROR by 3; mode/amount/start changes while busy must not matter.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 4'd3);
        stepCycle("ror_e0", 8'hB4, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 4'd15);
        stepCycle("ror_e1", 8'h5A, 1'b0, 1'b1, 1'b0);
        stepCycle("ror_e2", 8'h2D, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 4'd0);
        stepCycle("ror_e3", 8'h96, 1'b1, 1'b1, 1'b1);
        stepCycle("ror_e4", 8'h96, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 8'h90, 1'b0, 3'd0, 4'd0);
        stepCycle("load_90", 8'h90, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 4'd2);
        stepCycle("asr_e0", 8'h90, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 4'd0);
        stepCycle("asr_e1", 8'hC8, 1'b0, 1'b1, 1'b0);
        stepCycle("asr_e2", 8'hE4, 1'b0, 1'b1, 1'b1);
        stepCycle("asr_e3", 8'hE4, 1'b0, 1'b0, 1'b0);

        // LSL by 9 on an 8-bit word: ones fall out until the word empties.
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 4'd0);
        stepCycle("load_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 4'd9);
        stepCycle("lsl_e0", 8'hFF, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 4'd0);
        for (int k = 1; k <= 9; k++) begin
            lslExp = 8'hFF;
            lslExp = (k >= 8) ? 8'h00 : (lslExp << k);
            stepCycle($sformatf("lsl_e%0d", k), lslExp, (k <= 8), 1'b1, (k == 9));
        end
        stepCycle("lsl_e10", 8'h00, 1'b0, 1'b0, 1'b0);

        // Zero-distance and reserved-mode starts complete immediately; DONE ignores start/load.
        applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0, 3'd0, 4'd0);
        stepCycle("load_5a", 8'h5A, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 4'd0);
        stepCycle("amt0_e0", 8'h5A, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 4'd3);
        stepCycle("amt0_e1", 8'h5A, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 3'd6, 4'd5);
        stepCycle("rsv_e0", 8'h5A, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1, 3'd0, 4'd2);
        stepCycle("rsv_e1", 8'h5A, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 4'd0);
        stepCycle("rsv_idle", 8'h5A, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 3'd0, 4'd0);
        stepCycle("load_01", 8'h01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 4'd5);
        stepCycle("rol_e0", 8'h01, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 4'd0);
        stepCycle("rol_e1", 8'h02, 1'b0, 1'b1, 1'b0);
        stepCycle("rol_e2", 8'h04, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0, 3'd0, 4'd0);
        stepCycle("abort_load", 8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 4'd0);
        stepCycle("abort_idle", 8'h3C, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 3'd0, 4'd0);
        stepCycle("load_01b", 8'h01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 4'd5);
        stepCycle("rolb_e0", 8'h01, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 4'd0);
        stepCycle("rolb_e1", 8'h02, 1'b0, 1'b1, 1'b0);
        stepCycle("rolb_e2", 8'h04, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 4'd0);
        stepCycle("abort_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 4'd0);
        stepCycle("reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_shift_register.md
# seq_shift_register

Parametrised multi-mode shift/rotate register with a sequenced multi-position shift. A single start request shifts or rotates the held word by `amount` positions, one bit position per clock, with a busy/done handshake. Parallel load and synchronous reset are kept from the 8-bit rotate register. It sits between switch/bus inputs and LED/datapath consumers wherever a variable-distance shift is needed without a barrel shifter.

## Interface
- `WIDTH`, 8, register width in bits (≥2)
- `AMT_W`, 4, width of `amount`; shifts up to 2^AMT_W−1 positions
- `clock`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `load`  in  1  parallel load request, active-high
- `data_in`  in  WIDTH  parallel load value
- `start`  in  1  begin sequenced shift, active-high, sampled in IDLE only
- `mode`  in  3  0 ROR, 1 ROL, 2 LSR, 3 LSL, 4 ASR, 5–7 reserved; sampled with `start`
- `amount`  in  AMT_W  number of one-bit steps; sampled with `start`
- `q`  out  WIDTH  register contents
- `shift_out`  out  1  bit that left the word on the most recent step
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT, DONE.
- Reset: `q` = 0, `shift_out` = 0, state = IDLE, `busy` = 0, `done` = 0. Reset overrides everything, including an operation in progress.
- IDLE with `load`=1: `q` ← `data_in`, `shift_out` ← 0. Load has priority over `start`.
- IDLE with `start`=1 and `load`=0:
  - `amount`=0 or reserved mode: go to DONE; `q` is unchanged.
  - Otherwise latch `mode` into `mode_r`, set count ← `amount`, go to SHIFT.
- SHIFT: each cycle applies one step of `mode_r` and decrements count. When a step is taken with count=1, go to DONE.
  - ROR: `q` ← {q[0], q[W−1:1]}, out = q[0]
  - ROL: `q` ← {q[W−2:0], q[W−1]}, out = q[W−1]
  - LSR: `q` ← {0, q[W−1:1]}, out = q[0]
  - LSL: `q` ← {q[W−2:0], 0}, out = q[W−1]
  - ASR: `q` ← {q[W−1], q[W−1:1]}, out = q[0]
- SHIFT with `load`=1: abort. `q` ← `data_in`, `shift_out` ← 0, go to IDLE, no `done` pulse.
- DONE: `done`=1 for one cycle, then go to IDLE. `start` is ignored in this state.
- `start` while busy is ignored. Changes to `mode` or `amount` during SHIFT have no effect.
- `amount` ≥ WIDTH is legal and executes literally:
  - Rotates wrap around.
  - LSR/LSL reach all-zero.
  - ASR reaches all-sign.

## Timing
- Let edge 0 be the edge that samples `start`.
- Shifts occur on edges 1..N, where N = `amount`. `q` shows the k-th step after edge k.
- `done` is high between edge N and edge N+1. `busy` is high from edge 0 to edge N+1.
- For N=0 or a reserved mode, `done` is high between edge 0 and edge 1.
- Load latency is 1 edge in IDLE or SHIFT. `load` is ignored in the DONE state.
- `start` may be reasserted in the cycle after DONE; the next operation begins on that edge.
- Back-to-back throughput is N+2 cycles per operation.

## Structure
- Package `seq_shift_pkg`:
  - mode enum (ROR, ROL, LSR, LSL, ASR)
  - state enum (IDLE, SHIFT, DONE)
  - function `is_reserved(mode)`
- Sub-module `shift_step_unit`: combinational one-bit step. Inputs `q` and `mode_r`; outputs next `q` and `out` bit. Parametrised by WIDTH.
- Top module holds the FSM, counter, `mode_r`, `q` and `shift_out` registers.

## Test plan
All cases use WIDTH=8.
- Reset, then load 0xB4 → `q`=0xB4, `shift_out`=0, `busy`=0, `done`=0.
- From 0xB4, ROR with amount 3 → `q` steps 0x5A, 0x2D, 0x96; `busy` high for 4 cycles; `done` pulses once; final `shift_out`=1.
- Load 0x90, then ASR with amount 2 → `q` steps 0xC8, 0xE4; `shift_out`=0; `done` high in the cycle after edge 2.
- Load 0xFF, then LSL with amount 9 → `q`=0x00 after edge 8 and unchanged after edge 9; `shift_out`=0; `done` high after edge 9.
- Start with amount 0, then start with mode 6 and amount 5:
  - Each produces `done` in the cycle after edge 0 and `busy` for 1 cycle.
  - `q` is unchanged in both cases.
  - `start` pulses sent while busy are ignored.
- Abort paths:
  - Load 0x01, ROL with amount 5, assert load with 0x3C after edge 2 → `q`=0x3C, IDLE, no `done`.
  - Repeat with `reset` asserted instead → `q`=0, `busy`=0, `done`=0.
